// File: rtl/fe_ic_fb_resp_pkg.sv
// Shared types for the fetch-buffer to IC request/response path.
// Holds the packet structs, the ID tag type and the per-ID tracker entry.
package fe_ic_fb_resp_pkg;

  localparam int FE_NUM_FB_DEF    = 4;
  localparam int FE_MAX_OUTST_DEF = 4;
  localparam int FE_IC_ID_W       = $clog2(FE_MAX_OUTST_DEF);
  localparam int FE_FB_IDX_W      = $clog2(FE_NUM_FB_DEF);
  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;

  typedef logic [FE_IC_ID_W-1:0] t_fe_ic_id;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } t_mem_req_pkt;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } t_mem_rsp_pkt;

  typedef struct packed {
    logic                   busy;
    logic [FE_FB_IDX_W-1:0] owner;
  } t_fe_ic_trk;

endpackage

// File: rtl/fe_ic_fb_resp_if.sv
// Bundle of the FB-entry request/response lines and the IC port.
// master = the responder, slave = the FB array plus IC pipeline side.
interface fe_ic_fb_resp_if
  import fe_ic_fb_resp_pkg::*;
#(
  parameter int NUM_FB = FE_NUM_FB_DEF,
  parameter int ID_W   = FE_IC_ID_W
) ();

  logic         [NUM_FB-1:0] fb_req_rq;
  t_mem_req_pkt [NUM_FB-1:0] fb_req_pkt;
  logic         [NUM_FB-1:0] fb_req_gn;
  t_mem_rsp_pkt [NUM_FB-1:0] fb_rsp_pkt;
  logic                      ic_req_vld;
  t_mem_req_pkt              ic_req_pkt;
  logic         [ID_W-1:0]   ic_req_id;
  logic                      ic_req_rdy;
  t_mem_rsp_pkt              ic_rsp_pkt;
  logic         [ID_W-1:0]   ic_rsp_id;

  modport master (
    input  fb_req_rq, fb_req_pkt, ic_req_rdy, ic_rsp_pkt, ic_rsp_id,
    output fb_req_gn, fb_rsp_pkt, ic_req_vld, ic_req_pkt, ic_req_id
  );

  modport slave (
    output fb_req_rq, fb_req_pkt, ic_req_rdy, ic_rsp_pkt, ic_rsp_id,
    input  fb_req_gn, fb_rsp_pkt, ic_req_vld, ic_req_pkt, ic_req_id
  );

endinterface

// File: rtl/fe_rr_arb.sv
// Combinational round-robin arbiter: first request at or after i_ptr, circular.
// Produces a onehot0 grant plus the winner index.
module fe_rr_arb #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  logic [IW-1:0] w_j;

  // Scan from the far end back toward i_ptr so the closest request wins last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_j   = '0;
    o_any = |i_req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[w_j]) o_idx = w_j;
    end
    o_gnt[o_idx] = o_any;
  end

endmodule

// File: rtl/fe_ic_fb_resp.sv
// IC-side responder: arbitrates FB entry requests onto the IC port with an ID tag
// and routes each tagged response back to its owning entry one cycle later.
module fe_ic_fb_resp
  import fe_ic_fb_resp_pkg::*;
#(
  parameter int NUM_FB    = FE_NUM_FB_DEF,
  parameter int MAX_OUTST = FE_MAX_OUTST_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  fe_ic_fb_resp_if.master        bus,
  output logic                   busy
);

  localparam int IDX_W = FE_FB_IDX_W;
  localparam int ID_W  = FE_IC_ID_W;

  t_fe_ic_trk [MAX_OUTST-1:0] r_trk;
  logic       [IDX_W-1:0]     r_rr_ptr;
  logic                       r_rsp_vld_p1;
  logic       [IDX_W-1:0]     r_rsp_owner_p1;
  logic       [DATA_W-1:0]    r_rsp_data_p1;

  logic [MAX_OUTST-1:0]      w_busy_vec;
  logic                      w_any_free;
  t_fe_ic_id                 w_free_id;
  logic [NUM_FB-1:0]         w_arb_gnt;
  logic [IDX_W-1:0]          w_win;
  logic                      w_any_rq;
  logic                      w_can_issue;
  logic                      w_issue;
  logic                      w_rsp_hit;
  t_mem_req_pkt              w_req_pkt;
  t_mem_rsp_pkt [NUM_FB-1:0] w_fb_rsp;

  fe_rr_arb #(.NUM_REQ(NUM_FB)) u_arb (
    .i_req (bus.fb_req_rq),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_win),
    .o_any (w_any_rq)
  );

  // Free-list: lowest-index ID whose tracker is not busy.
  always_comb begin
    w_busy_vec = '0;
    w_free_id  = '0;
    w_any_free = 1'b0;
    for (int i = MAX_OUTST - 1; i >= 0; i--) begin
      w_busy_vec[i] = r_trk[i].busy;
      if (!r_trk[i].busy) begin
        w_free_id  = t_fe_ic_id'(i);
        w_any_free = 1'b1;
      end
    end
  end

  assign w_can_issue = bus.ic_req_rdy & w_any_free;
  assign w_issue     = w_can_issue & w_any_rq;
  assign w_rsp_hit   = bus.ic_rsp_pkt.valid & r_trk[bus.ic_rsp_id].busy;

  always_comb begin
    w_req_pkt       = bus.fb_req_pkt[w_win];
    w_req_pkt.valid = 1'b1;
  end

  assign bus.fb_req_gn  = w_can_issue ? w_arb_gnt : '0;
  assign bus.ic_req_vld = w_issue;
  assign bus.ic_req_pkt = w_req_pkt;
  assign bus.ic_req_id  = w_free_id;
  assign busy           = |w_busy_vec;

  // Stage p1: one shared response flop, decoded out to the owning entry.
  always_comb begin
    w_fb_rsp = '0;
    for (int i = 0; i < NUM_FB; i++) begin
      w_fb_rsp[i].valid = r_rsp_vld_p1 && (r_rsp_owner_p1 == IDX_W'(i));
      w_fb_rsp[i].data  = r_rsp_data_p1;
    end
  end

  assign bus.fb_rsp_pkt = w_fb_rsp;

  // Grant and response touch different IDs: the granted ID is free, a hit ID is busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_trk          <= '0;
      r_rr_ptr       <= '0;
      r_rsp_vld_p1   <= 1'b0;
      r_rsp_owner_p1 <= '0;
    end else begin
      r_rsp_vld_p1 <= w_rsp_hit;
      if (w_rsp_hit) begin
        r_rsp_owner_p1                <= r_trk[bus.ic_rsp_id].owner;
        r_trk[bus.ic_rsp_id].busy     <= 1'b0;
      end
      if (w_issue) begin
        r_trk[w_free_id].busy  <= 1'b1;
        r_trk[w_free_id].owner <= w_win;
        r_rr_ptr <= (w_win == IDX_W'(NUM_FB - 1)) ? '0 : w_win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rsp_hit) r_rsp_data_p1 <= bus.ic_rsp_pkt.data;
  end

`ifdef ASSERT
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(bus.fb_req_gn)) else $error("fb_req_gn not onehot0");
      assert ((bus.fb_req_gn & ~bus.fb_req_rq) == '0) else $error("grant without request");
      if (bus.ic_rsp_pkt.valid)
        assert (r_trk[bus.ic_rsp_id].busy) else $error("response for idle ID dropped");
      if (w_issue)
        for (int i = 0; i < MAX_OUTST; i++)
          assert (!(r_trk[i].busy && r_trk[i].owner == w_win))
            else $error("entry already owns an outstanding ID");
    end
  end
`endif

endmodule

// File: tb/tb_fe_ic_fb_resp.sv
// Randomised and directed bench for fe_ic_fb_resp against a behavioural model
// of the arbitration, ID allocation and response routing rules.
module tb_fe_ic_fb_resp;
  import fe_ic_fb_resp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  fe_ic_fb_resp_if #(.NUM_FB(4), .ID_W(FE_IC_ID_W)) bus ();

  fe_ic_fb_resp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state
  bit          m_busy [4];
  int          m_owner[4];
  int          m_rr;
  bit          m_pv;
  int          m_po;
  logic [31:0] m_pd;

  // Values captured at the last sampled negedge
  logic [3:0]  c_gn, c_rspv;
  logic        c_vld, c_busy;
  logic [1:0]  c_id;
  logic [31:0] c_addr;
  logic [31:0] c_rspd[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit outst(int e);
    for (int i = 0; i < 4; i++) if (m_busy[i] && m_owner[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_busy[i]  = 1'b0;
      m_owner[i] = 0;
    end
    m_rr = 0;
    m_pv = 1'b0;
    m_po = 0;
    m_pd = '0;
  endtask

  task automatic idle();
    reset              = 1'b0;
    bus.fb_req_rq      = '0;
    bus.fb_req_pkt     = '0;
    bus.ic_req_rdy     = 1'b0;
    bus.ic_rsp_pkt     = '0;
    bus.ic_rsp_id      = '0;
  endtask

  // Entered at posedge+1 with inputs set; checks at negedge, advances model, returns at next posedge+1.
  task automatic cyc();
    int         fid = -1;
    int         w   = -1;
    int         j;
    int         rid;
    bit         can, iss, anyb;
    logic [3:0] egn, erv;
    #4;
    for (int i = 0; i < 4; i++) if (!m_busy[i] && fid < 0) fid = i;
    can = bus.ic_req_rdy && (fid >= 0);
    for (int k = 0; k < 4; k++) begin
      j = (m_rr + k) % 4;
      if (bus.fb_req_rq[j] && w < 0) w = j;
    end
    iss  = can && (w >= 0);
    egn  = iss ? 4'(1 << w) : 4'b0;
    anyb = 1'b0;
    for (int i = 0; i < 4; i++) anyb |= m_busy[i];
    erv  = m_pv ? 4'(1 << m_po) : 4'b0;

    c_gn   = bus.fb_req_gn;
    c_vld  = bus.ic_req_vld;
    c_id   = bus.ic_req_id;
    c_addr = bus.ic_req_pkt.addr;
    c_busy = busy;
    for (int i = 0; i < 4; i++) begin
      c_rspv[i] = bus.fb_rsp_pkt[i].valid;
      c_rspd[i] = bus.fb_rsp_pkt[i].data;
    end

    chk("gn", c_gn, egn);
    chk("ic_vld", c_vld, iss);
    chk("busy", c_busy, anyb);
    chk("rsp_vld", c_rspv, erv);
    if (iss) begin
      chk("ic_id", c_id, fid);
      chk("ic_addr", c_addr, bus.fb_req_pkt[w].addr);
      chk("ic_pktv", bus.ic_req_pkt.valid, 1'b1);
    end
    if (m_pv) chk("rsp_data", c_rspd[m_po], m_pd);

    if (reset) begin
      model_reset();
    end else begin
      rid  = int'(bus.ic_rsp_id);
      m_pv = 1'b0;
      if (bus.ic_rsp_pkt.valid && m_busy[rid]) begin
        m_pv        = 1'b1;
        m_po        = m_owner[rid];
        m_pd        = bus.ic_rsp_pkt.data;
        m_busy[rid] = 1'b0;
      end
      if (iss) begin
        m_busy[fid]  = 1'b1;
        m_owner[fid] = w;
        m_rr         = (w + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic rsp(input int id, input logic [31:0] data);
    bus.ic_rsp_id        = 2'(id);
    bus.ic_rsp_pkt.valid = 1'b1;
    bus.ic_rsp_pkt.data  = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rr_exp[5];
    logic [1:0] prev_id;
    int         free_cnt;
    int         pick;
    int         ids[$];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;

    // Reset state
    cyc();
    chk("rst_busy", c_busy, 1'b0);
    chk("rst_gn", c_gn, 4'b0);
    chk("rst_rspv", c_rspv, 4'b0);

    // Single request
    reset_dut();
    bus.fb_req_rq           = 4'b0100;
    bus.fb_req_pkt[2].addr  = 32'h0000_1040;
    bus.fb_req_pkt[2].valid = 1'b1;
    bus.ic_req_rdy          = 1'b1;
    cyc();
    chk("sr_gn", c_gn, 4'b0100);
    chk("sr_id", c_id, 2'd0);
    chk("sr_addr", c_addr, 32'h0000_1040);
    bus.fb_req_rq = '0;
    rsp(0, 32'hA5A5_A5A5);
    cyc();
    bus.ic_rsp_pkt.valid = 1'b0;
    cyc();
    chk("sr_rspv", c_rspv, 4'b0100);
    chk("sr_rspd", c_rspd[2], 32'hA5A5_A5A5);
    cyc();
    chk("sr_rsp_once", c_rspv, 4'b0000);

    // Round robin with prompt responses
    reset_dut();
    bus.fb_req_rq  = 4'b1111;
    bus.ic_req_rdy = 1'b1;
    prev_id        = '0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) rsp(int'(prev_id), 32'h100 + k);
      cyc();
      chk("rr_gn", c_gn, rr_exp[k]);
      prev_id = c_id;
    end
    bus.ic_rsp_pkt.valid = 1'b0;
    bus.fb_req_rq        = '0;
    cyc();

    // Full
    reset_dut();
    bus.fb_req_rq  = 4'b1111;
    bus.ic_req_rdy = 1'b1;
    repeat (4) cyc();
    bus.fb_req_rq = 4'b0001;
    cyc();
    chk("full_gn", c_gn, 4'b0);
    chk("full_vld", c_vld, 1'b0);
    chk("full_busy", c_busy, 1'b1);
    rsp(1, 32'h1111_2222);
    cyc();
    chk("full_gn_n", c_gn, 4'b0);
    bus.ic_rsp_pkt.valid = 1'b0;
    cyc();
    chk("full_gn_n1", c_gn, 4'b0001);
    chk("full_id", c_id, 2'd1);
    chk("full_rspv", c_rspv, 4'b0010);
    chk("full_rspd", c_rspd[1], 32'h1111_2222);

    // Backpressure
    reset_dut();
    bus.fb_req_rq  = 4'b0010;
    bus.ic_req_rdy = 1'b0;
    repeat (3) begin
      cyc();
      chk("bp_gn", c_gn, 4'b0);
      chk("bp_busy", c_busy, 1'b0);
    end
    bus.ic_req_rdy = 1'b1;
    cyc();
    chk("bp_gn_rdy", c_gn, 4'b0010);

    // Out-of-order responses
    reset_dut();
    bus.ic_req_rdy         = 1'b1;
    bus.fb_req_rq          = 4'b1000;
    bus.fb_req_pkt[3].addr = 32'h0000_3000;
    cyc();
    chk("ooo_id0", c_id, 2'd0);
    bus.fb_req_rq          = 4'b0001;
    bus.fb_req_pkt[0].addr = 32'h0000_0400;
    cyc();
    chk("ooo_id1", c_id, 2'd1);
    bus.fb_req_rq = '0;
    rsp(1, 32'hDEAD_0001);
    cyc();
    rsp(0, 32'hBEEF_0000);
    cyc();
    chk("ooo_v0", c_rspv, 4'b0001);
    chk("ooo_d0", c_rspd[0], 32'hDEAD_0001);
    bus.ic_rsp_pkt.valid = 1'b0;
    cyc();
    chk("ooo_v3", c_rspv, 4'b1000);
    chk("ooo_d3", c_rspd[3], 32'hBEEF_0000);

    // Reset mid-flight
    reset_dut();
    bus.ic_req_rdy = 1'b1;
    bus.fb_req_rq  = 4'b0001;
    cyc();
    bus.fb_req_rq  = 4'b0010;
    cyc();
    bus.fb_req_rq  = '0;
    reset          = 1'b1;
    cyc();
    reset = 1'b0;
    rsp(0, 32'h7777_7777);
    cyc();
    chk("rm_busy", c_busy, 1'b0);
    bus.ic_rsp_pkt.valid = 1'b0;
    cyc();
    chk("rm_rspv", c_rspv, 4'b0);
    bus.fb_req_rq = 4'b1111;
    cyc();
    chk("rm_gn", c_gn, 4'b0001);
    chk("rm_id", c_id, 2'd0);

    // Randomised traffic
    reset_dut();
    for (int n = 0; n < 500; n++) begin
      reset          = ($urandom_range(0, 149) == 0);
      bus.ic_req_rdy = ($urandom_range(0, 3) != 0);
      for (int e = 0; e < 4; e++) begin
        if (outst(e)) begin
          bus.fb_req_rq[e] = 1'b0;
        end else if (!bus.fb_req_rq[e] && $urandom_range(0, 2) == 0) begin
          bus.fb_req_rq[e]        = 1'b1;
          bus.fb_req_pkt[e].addr  = $urandom;
          bus.fb_req_pkt[e].valid = 1'b1;
        end
      end
      ids.delete();
      free_cnt = 0;
      for (int i = 0; i < 4; i++) if (m_busy[i]) ids.push_back(i); else free_cnt++;
      bus.ic_rsp_pkt.valid = 1'b0;
      if (ids.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick = ids[$urandom_range(0, ids.size() - 1)];
        rsp(pick, $urandom);
      end else if (free_cnt > 0 && $urandom_range(0, 15) == 0) begin
        for (int i = 0; i < 4; i++) if (!m_busy[i]) pick = i;
        rsp(pick, $urandom);
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
